// File: rtl/ro_bus_capture.sv
// Captures readout-line samples on single-bit gray timebase steps into a record FIFO.
// Optional macro RO_CAP_ZERO_SUPPRESS_EN drops records whose readout lines are both 0.
module ro_bus_capture #(
    parameter int unsigned GW    = 19,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_master,
    input  logic                       rstb,
    input  logic                       en,
    input  logic [GW-1:0]              gray,
    input  logic                       ro_eve,
    input  logic                       ro_pol_eve,
    output logic [6:0]                 rec_data,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       gray_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = 5;
    localparam int unsigned RW = 7;

    logic [GW-1:0] r_gray_q;
    logic [GW-1:0] w_diff;
    logic          w_one_hot;
    logic          w_multi;
    logic [IW-1:0] w_ch_idx;
    logic          w_keep;
    logic          w_push_req;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [RW-1:0] w_rec;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [RW-1:0] r_mem [DEPTH];
    logic          r_overflow;
    logic          r_gray_err;

    // Step classification: exactly one toggled bit is a slot event, more is an error.
    assign w_diff    = gray ^ r_gray_q;
    assign w_one_hot = (w_diff != '0) && ((w_diff & (w_diff - GW'(1))) == '0);
    assign w_multi   = (w_diff != '0) && !w_one_hot;

    always_comb begin
        w_ch_idx = '0;
        for (int unsigned i = 0; i < GW; i++) begin
            if (w_diff[i]) begin
                w_ch_idx = IW'(i);
            end
        end
    end

`ifdef RO_CAP_ZERO_SUPPRESS_EN
    assign w_keep = ro_eve | ro_pol_eve;
`else
    assign w_keep = 1'b1;
`endif

    assign w_rec      = {w_ch_idx, ro_pol_eve, ro_eve};
    assign w_push_req = w_one_hot && en && w_keep;
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_pop      = (r_level != '0) && rec_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    // Control state: timebase copy, pointers, level and sticky flags.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            r_gray_q   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_gray_err <= 1'b0;
        end else begin
            r_gray_q <= gray;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_multi) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    // Record storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk_master) begin
        if (rstb && w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign rec_valid  = (r_level != '0);
    assign rec_data   = rec_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign gray_err   = r_gray_err;

endmodule

// File: tb/tb_ro_bus_capture.sv
// Self-checking bench for ro_bus_capture: directed scenarios then randomized traffic vs a queue model.
module tb_ro_bus_capture;

    localparam int unsigned GW    = 19;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          en = 1'b0;
    logic [GW-1:0] gray = '0;
    logic          ro_eve = 1'b0;
    logic          ro_pol_eve = 1'b0;
    logic          rec_ready = 1'b0;
    logic [6:0]    rec_data;
    logic          rec_valid;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          gray_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [GW-1:0] m_prev = '0;
    logic [6:0]    m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_err = 1'b0;
    logic [GW-1:0] gc = '0;

    ro_bus_capture #(.GW(GW), .DEPTH(DEPTH)) dut (
        .clk_master (clk),
        .rstb       (rstb),
        .en         (en),
        .gray       (gray),
        .ro_eve     (ro_eve),
        .ro_pol_eve (ro_pol_eve),
        .rec_data   (rec_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .gray_err   (gray_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural view of one clock edge.
    task automatic model_edge();
        logic [GW-1:0] d;
        int            n;
        int            idx;
        logic          keep;
        logic          popped;
        if (!rstb) begin
            m_q.delete();
            m_prev = '0;
            m_ovf  = 1'b0;
            m_err  = 1'b0;
            return;
        end
        d      = gray ^ m_prev;
        n      = $countones(d);
        popped = (m_q.size() != 0) && rec_ready;
        if (popped) void'(m_q.pop_front());
        if (n >= 2) m_err = 1'b1;
`ifdef RO_CAP_ZERO_SUPPRESS_EN
        keep = ro_eve || ro_pol_eve;
`else
        keep = 1'b1;
`endif
        if (n == 1 && en && keep) begin
            idx = $clog2(d);
            if (m_q.size() < DEPTH) m_q.push_back({5'(idx), ro_pol_eve, ro_eve});
            else m_ovf = 1'b1;
        end
        m_prev = gray;
    endtask

    task automatic check_all();
        chk("rec_valid", 32'(rec_valid), 32'(m_q.size() != 0));
        chk("rec_data", 32'(rec_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("gray_err", 32'(gray_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        gray = '0;
        gc   = '0;
        cycle();
        rstb = 1'b1;
    endtask

    task automatic gray_step();
        gc   = gc + GW'(1);
        gray = gc ^ (gc >> 1);
    endtask

    initial begin
        int ready_pct;
        int r;
        int b1;
        int b2;

        // Reset state
        do_reset();
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_data", 32'(rec_data), 32'd0);

        // Counting gray from 0: first record and ch_idx of step 1->3
        en = 1'b1; ro_eve = 1'b1; ro_pol_eve = 1'b0; rec_ready = 1'b1;
        gray_step();
        cycle();
        chk("first_rec", 32'(rec_data), 32'h01);
        gray_step();
        cycle();
        chk("second_rec", 32'(rec_data), 32'h05);
        for (int i = 0; i < 10; i++) begin
            gray_step();
            cycle();
        end

        // Full case: 9 events without ready, then drain in order
        do_reset();
        en = 1'b1; rec_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ro_eve = 1'($urandom_range(0, 1)); ro_pol_eve = 1'b1;
            gray_step();
            cycle();
        end
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ovf", 32'(overflow), 32'd1);
        rec_ready = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        chk("drained_level", 32'(fifo_level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full plus pop in the same cycle as an event
        do_reset();
        rec_ready = 1'b0; ro_eve = 1'b1; ro_pol_eve = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gray_step();
            cycle();
        end
        rec_ready = 1'b1;
        gray_step();
        cycle();
        chk("fullpop_level", 32'(fifo_level), 32'd8);
        chk("fullpop_ovf", 32'(overflow), 32'd0);

        // Bad gray step 0->3
        do_reset();
        rec_ready = 1'b0;
        gray = GW'(3);
        cycle();
        chk("bad_level", 32'(fifo_level), 32'd0);
        chk("bad_err", 32'(gray_err), 32'd1);
        gray = GW'(2);
        for (int i = 0; i < 4; i++) cycle();
        chk("err_sticky", 32'(gray_err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(gray_err), 32'd0);

        // Mid-stream reset with 5 queued records
        rec_ready = 1'b0; ro_eve = 1'b1;
        for (int i = 0; i < 5; i++) begin
            gray_step();
            cycle();
        end
        chk("queued5", 32'(fifo_level), 32'd5);
        rec_ready = 1'b1;
        do_reset();
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_valid", 32'(rec_valid), 32'd0);

        // en=0 blocks records while gray tracks
        en = 1'b0; rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gray_step();
            cycle();
        end
        chk("en0_level", 32'(fifo_level), 32'd0);
        en = 1'b1;

        // Both lines zero on 4 events
        do_reset();
        ro_eve = 1'b0; ro_pol_eve = 1'b0; rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gray_step();
            cycle();
        end
`ifdef RO_CAP_ZERO_SUPPRESS_EN
        chk("zero_supp", 32'(fifo_level), 32'd0);
`else
        chk("zero_supp", 32'(fifo_level), 32'd4);
`endif

        // Randomized traffic
        do_reset();
        ready_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) ready_pct = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 50 : 90);
            en         = ($urandom_range(0, 99) < 85);
            ro_eve     = 1'($urandom_range(0, 1));
            ro_pol_eve = 1'($urandom_range(0, 1));
            rec_ready  = ($urandom_range(0, 99) < ready_pct);
            r = $urandom_range(0, 999);
            if (r < 10) begin
                rstb = 1'b0;
                gray = '0;
            end else begin
                rstb = 1'b1;
                if (r < 600) begin
                    b1 = $urandom_range(0, GW - 1);
                    gray[b1] = ~gray[b1];
                end else if (r < 615) begin
                    b1 = $urandom_range(0, GW - 1);
                    b2 = (b1 + $urandom_range(1, GW - 1)) % GW;
                    gray[b1] = ~gray[b1];
                    gray[b2] = ~gray[b2];
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
